// File: rtl/ddc1.sv
// Shared 1-bit to n-bit signed converter: bit 1 maps to +max and bit 0 maps to min.
`ifndef DDC1_SV
`define DDC1_SV

module ddc1 #(
  parameter int n = 16
) (
  input  logic                in,
  output logic signed [n-1:0] out
);

  function automatic logic signed [n-1:0] sat1(input logic b);
    return b ? {1'b0, {(n-1){1'b1}}} : {1'b1, {(n-1){1'b0}}};
  endfunction

  assign out = sat1(in);

endmodule

`endif

// File: rtl/ddc1_arb.sv
// Round-robin arbiter sharing one ddc1 across k strobed 1-bit channels,
// with one-entry slots per channel, sticky overrun flags and a valid/ready output register.
`ifndef DDC1_ARB_SV
`define DDC1_ARB_SV

module ddc1_arb #(
  parameter  int n  = 16,
  parameter  int k  = 4,
  localparam int cw = $clog2(k)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [k-1:0]  in,
  input  logic [k-1:0]  in_stb,
  input  logic          ovf_clr,
  output logic [k-1:0]  ovf,
  output logic [n-1:0]  out,
  output logic [cw-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [k-1:0]         pending_q, pending_d;
  logic [k-1:0]         slot_q, slot_d;
  logic [k-1:0]         ovf_q, ovf_d;
  logic [cw-1:0]        ptr_q, ptr_d;
  logic signed [n-1:0]  out_q;
  logic [cw-1:0]        out_ch_q;
  logic                 out_valid_q;

  logic                 free;
  logic                 gnt_vld;
  logic [cw-1:0]        gnt_idx;
  logic [cw-1:0]        scan;
  logic signed [n-1:0]  conv;

  assign free = !out_valid_q || out_ready;

  // Scan from ptr with explicit wrap so non-power-of-two k never reaches index k.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = ptr_q;
    for (int i = 0; i < k; i++) begin
      if (!gnt_vld && free && pending_q[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan;
      end
      scan = (scan == cw'(k - 1)) ? '0 : scan + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < k; c++) begin
      if (gnt_vld && gnt_idx == cw'(c)) begin
        // A strobe into the granted slot refills it; the old bit is being consumed, so no overrun.
        pending_d[c] = in_stb[c];
        ovf_d[c]     = ovf_q[c] && !ovf_clr;
      end else begin
        pending_d[c] = pending_q[c] || in_stb[c];
        ovf_d[c]     = (ovf_q[c] && !ovf_clr) || (in_stb[c] && pending_q[c]);
      end
      slot_d[c] = in_stb[c] ? in[c] : slot_q[c];
    end
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == cw'(k - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  ddc1 #(.n(n)) u_ddc1 (
    .in  (slot_q[gnt_idx]),
    .out (conv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      slot_q      <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      slot_q    <= slot_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      if (gnt_vld) begin
        out_q       <= conv;
        out_ch_q    <= gnt_idx;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ovf       = ovf_q;
  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

`endif

// File: tb/tb_ddc1_arb.sv
// Directed bench for ddc1_arb: a k=4 instance and a k=3 instance sharing clock and reset.
module tb_ddc1_arb;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  in4, stb4, ovf4;
  logic        clr4, rdy4, vld4;
  logic [15:0] out4;
  logic [1:0]  ch4;

  logic [2:0]  in3, stb3, ovf3;
  logic        clr3, rdy3, vld3;
  logic [15:0] out3;
  logic [1:0]  ch3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddc1_arb #(.n(16), .k(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .in_stb(stb4), .ovf_clr(clr4), .ovf(ovf4),
    .out(out4), .out_ch(ch4), .out_valid(vld4), .out_ready(rdy4)
  );

  ddc1_arb #(.n(16), .k(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .in_stb(stb3), .ovf_clr(clr3), .ovf(ovf3),
    .out(out3), .out_ch(ch3), .out_valid(vld3), .out_ready(rdy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in4 = '0; stb4 = '0; clr4 = 1'b0; rdy4 = 1'b1;
    in3 = '0; stb3 = '0; clr3 = 1'b0; rdy3 = 1'b1;
    step();
    step();
    chk("rst_out", out4, 16'h0000);
    chk("rst_ch", ch4, 2'd0);
    chk("rst_vld", vld4, 1'b0);
    chk("rst_ovf", ovf4, 4'b0000);
    rst_n = 1'b1;
    step();

    // single sample, bit 1 on channel 2
    stb4 = 4'b0100; in4 = 4'b0100;
    step();
    stb4 = '0; in4 = '0;
    chk("single1_lat", vld4, 1'b0);
    step();
    chk("single1_vld", vld4, 1'b1);
    chk("single1_out", out4, 16'h7FFF);
    chk("single1_ch", ch4, 2'd2);
    step();
    chk("single1_drop", vld4, 1'b0);

    // single sample, bit 0 on channel 2
    stb4 = 4'b0100; in4 = 4'b0000;
    step();
    stb4 = '0;
    chk("single0_lat", vld4, 1'b0);
    step();
    chk("single0_vld", vld4, 1'b1);
    chk("single0_out", out4, 16'h8000);
    chk("single0_ch", ch4, 2'd2);
    step();
    chk("single0_drop", vld4, 1'b0);

    // reset mid-stream: out_valid held by a stall, channels 0 and 2 pending
    rdy4 = 1'b0;
    stb4 = 4'b0010; in4 = 4'b0000;
    step();
    stb4 = 4'b0101; in4 = 4'b0101;
    step();
    stb4 = '0;
    chk("mid_pre_vld", vld4, 1'b1);
    chk("mid_pre_ch", ch4, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out4, 16'h0000);
    chk("mid_rst_vld", vld4, 1'b0);
    chk("mid_rst_ch", ch4, 2'd0);
    step();
    rst_n = 1'b1; rdy4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_post_vld", vld4, 1'b0);
    end

    // fairness: all pending, each channel restrobed in its own grant cycle
    in4 = 4'b0101;
    stb4 = 4'b1111;
    step();
    for (int i = 0; i < 8; i++) begin
      stb4 = 4'b0001 << (i % 4);
      step();
      chk("fair_vld", vld4, 1'b1);
      chk("fair_ch", ch4, 32'(i % 4));
      chk("fair_out", out4, ((i % 2) == 0) ? 16'h7FFF : 16'h8000);
    end
    stb4 = '0;
    chk("fair_ovf", ovf4, 4'b0000);
    for (int i = 0; i < 4; i++) step();
    step();
    chk("fair_drain", vld4, 1'b0);

    // backpressure on channel 1, bits 1,0,1,1,0
    rdy4 = 1'b0;
    stb4 = 4'b0010;
    in4 = 4'b0010; step();
    in4 = 4'b0000; step();
    chk("bp_first_out", out4, 16'h7FFF);
    chk("bp_first_ch", ch4, 2'd1);
    in4 = 4'b0010; step();
    in4 = 4'b0010; step();
    in4 = 4'b0000; step();
    stb4 = '0;
    step();
    chk("bp_hold_vld", vld4, 1'b1);
    chk("bp_hold_out", out4, 16'h7FFF);
    chk("bp_hold_ch", ch4, 2'd1);
    chk("bp_ovf", ovf4, 4'b0010);
    rdy4 = 1'b1;
    step();
    chk("bp_last_vld", vld4, 1'b1);
    chk("bp_last_out", out4, 16'h8000);
    chk("bp_last_ch", ch4, 2'd1);
    step();
    chk("bp_empty", vld4, 1'b0);
    chk("bp_ovf_sticky", ovf4, 4'b0010);
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    chk("bp_ovf_clr", ovf4, 4'b0000);

    // overrun and clear in the same cycle: the set wins
    rdy4 = 1'b0;
    stb4 = 4'b0001; in4 = 4'b0001;
    step();
    step();
    chk("setwin_pre", ovf4, 4'b0000);
    clr4 = 1'b1;
    step();
    stb4 = '0;
    chk("setwin_ovf", ovf4, 4'b0001);
    step();
    clr4 = 1'b0;
    chk("setwin_clr", ovf4, 4'b0000);
    rdy4 = 1'b1;
    step();
    step();
    chk("setwin_drain", vld4, 1'b0);

    // channel 3 strobed again in its grant cycle with the opposite bit
    stb4 = 4'b1000; in4 = 4'b1000;
    step();
    in4 = 4'b0000;
    step();
    stb4 = '0;
    chk("simul_old_out", out4, 16'h7FFF);
    chk("simul_old_ch", ch4, 2'd3);
    step();
    chk("simul_new_vld", vld4, 1'b1);
    chk("simul_new_out", out4, 16'h8000);
    chk("simul_new_ch", ch4, 2'd3);
    chk("simul_ovf", ovf4, 4'b0000);
    step();
    chk("simul_drain", vld4, 1'b0);

    // k=3: pointer wraps 2 -> 0
    in3 = 3'b010;
    stb3 = 3'b111;
    step();
    for (int i = 0; i < 6; i++) begin
      stb3 = 3'b001 << (i % 3);
      step();
      chk("k3_vld", vld3, 1'b1);
      chk("k3_ch", ch3, 32'(i % 3));
      chk("k3_out", out3, ((i % 3) == 1) ? 16'h7FFF : 16'h8000);
    end
    stb3 = '0;
    chk("k3_ovf", ovf3, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
